// File: rtl/fir_sym_param_pkg.sv
// Shared helpers for the parametrised symmetric FIR: width arithmetic and
// saturation limits used by the filter core and the reusable round/saturate stage.
package fir_pkg;

  localparam int SAT_LIM_W = 128;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision accumulator width: pre-add growth, product, then sum of TAPS/2 products
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + 1 + coef_w + clog2(taps / 2);
  endfunction

  function automatic logic signed [SAT_LIM_W-1:0] sat_max(input int out_w);
    logic signed [SAT_LIM_W-1:0] one;
    one = {{(SAT_LIM_W-1){1'b0}}, 1'b1};
    return (one <<< (out_w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_LIM_W-1:0] sat_min(input int out_w);
    logic signed [SAT_LIM_W-1:0] one;
    one = {{(SAT_LIM_W-1){1'b0}}, 1'b1};
    return {SAT_LIM_W{1'b0}} - (one <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_sym_param_if.sv
// Sample, coefficient-load and filtered-output signals of the symmetric FIR.
interface fir_sym_param_if import fir_pkg::*; #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 16
);
  localparam int ADDR_W = clog2(TAPS / 2);

  logic                     din_valid;
  logic signed [DATA_W-1:0] din;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     dout_valid;
  logic signed [OUT_W-1:0]  dout;
  logic                     dout_sat;

  modport master (
    output din_valid, din, coef_we, coef_addr, coef_data, coef_commit,
    input  dout_valid, dout, dout_sat
  );

  modport slave (
    input  din_valid, din, coef_we, coef_addr, coef_data, coef_commit,
    output dout_valid, dout, dout_sat
  );

endinterface

// File: rtl/fir_sym_param_round_sat.sv
// Registered round-half-up, arithmetic shift and saturation of a wide signed sum.
// Output value and saturation flag hold between valid samples.
module fir_round_sat import fir_pkg::*; #(
  parameter int IN_W  = 28,
  parameter int SHIFT = 12,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  sum_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    sat_o
);
  // One guard bit so adding the rounding constant can never wrap
  localparam int R_W    = IN_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [R_W-1:0] ONE_C = {{(R_W-1){1'b0}}, 1'b1};
  localparam logic signed [R_W-1:0] RND_C = (SHIFT > 0) ? (ONE_C <<< RND_SH) : {R_W{1'b0}};
  localparam logic signed [SAT_LIM_W-1:0] MAX_C = sat_max(OUT_W);
  localparam logic signed [SAT_LIM_W-1:0] MIN_C = sat_min(OUT_W);

  logic signed [R_W-1:0]       ext_s;
  logic signed [R_W-1:0]       rnd_s;
  logic signed [R_W-1:0]       r_s;
  logic signed [SAT_LIM_W-1:0] r_wide_s;
  logic signed [OUT_W-1:0]     dout_d, dout_q;
  logic                        sat_d, sat_q;
  logic                        valid_q;

  // Round, shift and clip; hold the previous result when no sample arrives
  always_comb begin
    ext_s    = {sum_i[IN_W-1], sum_i};
    rnd_s    = ext_s + RND_C;
    r_s      = rnd_s >>> SHIFT;
    r_wide_s = {{(SAT_LIM_W-R_W){r_s[R_W-1]}}, r_s};
    dout_d   = dout_q;
    sat_d    = sat_q;
    if (valid_i) begin
      if (r_wide_s > MAX_C) begin
        dout_d = MAX_C[OUT_W-1:0];
        sat_d  = 1'b1;
      end else if (r_wide_s < MIN_C) begin
        dout_d = MIN_C[OUT_W-1:0];
        sat_d  = 1'b1;
      end else begin
        dout_d = r_wide_s[OUT_W-1:0];
        sat_d  = 1'b0;
      end
    end else begin
      dout_d = dout_q;
      sat_d  = sat_q;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dout_q  <= {OUT_W{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = dout_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/fir_sym_param.sv
// Parametrised symmetric FIR: valid-qualified delay line, pre-add, multiply,
// full-precision sum, then round/saturate; double-buffered coefficient banks.
module fir_sym_param import fir_pkg::*; #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 12
) (
  input logic            clk,
  input logic            rst,
  fir_sym_param_if.slave bus
);
  localparam int HALF   = TAPS / 2;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] x_d      [TAPS];
  logic signed [DATA_W-1:0] x_q      [TAPS];
  logic signed [PRE_W-1:0]  p_d      [HALF];
  logic signed [PRE_W-1:0]  p_q      [HALF];
  logic signed [PROD_W-1:0] m_d      [HALF];
  logic signed [PROD_W-1:0] m_q      [HALF];
  logic signed [COEF_W-1:0] shadow_d [HALF];
  logic signed [COEF_W-1:0] shadow_q [HALF];
  logic signed [COEF_W-1:0] active_d [HALF];
  logic signed [COEF_W-1:0] active_q [HALF];
  logic signed [ACC_W-1:0]  sum_d, sum_q;
  // Tags for delay-line head, pre-add, product and sum stages
  logic [3:0]               vld_d, vld_q;

  // Delay line advances only on accepted samples
  always_comb begin
    for (int k = 0; k < TAPS; k++) x_d[k] = x_q[k];
    if (bus.din_valid) begin
      x_d[0] = bus.din;
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end else begin
      for (int k = 0; k < TAPS; k++) x_d[k] = x_q[k];
    end
  end

  for (genvar i = 0; i < HALF; i++) begin : g_pair
    assign p_d[i] = $signed({x_q[i][DATA_W-1], x_q[i]})
                  + $signed({x_q[TAPS-1-i][DATA_W-1], x_q[TAPS-1-i]});
    assign m_d[i] = $signed({{COEF_W{p_q[i][PRE_W-1]}}, p_q[i]})
                  * $signed({{PRE_W{active_q[i][COEF_W-1]}}, active_q[i]});
  end

  // Sum of products, extended so it cannot overflow
  always_comb begin
    sum_d = {ACC_W{1'b0}};
    for (int i = 0; i < HALF; i++) begin
      sum_d = sum_d + $signed({{(ACC_W-PROD_W){m_q[i][PROD_W-1]}}, m_q[i]});
    end
  end

  // Commit copies the pre-edge shadow, so a same-edge write misses that commit
  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
    end
    if (bus.coef_commit) begin
      for (int i = 0; i < HALF; i++) active_d[i] = shadow_q[i];
    end else begin
      for (int i = 0; i < HALF; i++) active_d[i] = active_q[i];
    end
    if (bus.coef_we && (int'(bus.coef_addr) < HALF)) begin
      shadow_d[bus.coef_addr] = bus.coef_data;
    end else begin
      for (int i = 0; i < HALF; i++) shadow_d[i] = shadow_q[i];
    end
    vld_d = {vld_q[2:0], bus.din_valid};
  end

  // Datapath, bank and valid-tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= {DATA_W{1'b0}};
      for (int i = 0; i < HALF; i++) begin
        p_q[i]      <= {PRE_W{1'b0}};
        m_q[i]      <= {PROD_W{1'b0}};
        shadow_q[i] <= {COEF_W{1'b0}};
        active_q[i] <= {COEF_W{1'b0}};
      end
      sum_q <= {ACC_W{1'b0}};
      vld_q <= 4'b0000;
    end else begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= x_d[k];
      for (int i = 0; i < HALF; i++) begin
        p_q[i]      <= p_d[i];
        m_q[i]      <= m_d[i];
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end

  fir_round_sat #(
    .IN_W  (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .clk     (clk),
    .rst     (rst),
    .valid_i (vld_q[3]),
    .sum_i   (sum_q),
    .valid_o (bus.dout_valid),
    .dout_o  (bus.dout),
    .sat_o   (bus.dout_sat)
  );

endmodule

// File: tb/tb_fir_sym_param.sv
// Scoreboard bench: two filters (SHIFT=0 and SHIFT=1) share one stimulus stream and are
// checked against an arithmetic model of the filter taken from its behavioural rules.
module tb_fir_sym_param;
  localparam int DATA_W = 12;
  localparam int COEF_W = 12;
  localparam int TAPS   = 16;
  localparam int OUT_W  = 16;
  localparam int HALF   = TAPS / 2;
  localparam int ADDR_W = 3;
  localparam int SH0    = 0;
  localparam int SH1    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_sym_param_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus0 ();
  fir_sym_param_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus1 ();

  fir_sym_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SH0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fir_sym_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SH1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int     due;
    longint d0;
    bit     s0;
    longint d1;
    bit     s1;
  } exp_t;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  exp_t sb_q[$];
  int   reset_due = -1;
  int   mon_start = 1 << 30;

  // Reference model state
  int   shadow_m[HALF];
  int   active_m[HALF];
  int   hist_m[TAPS];
  int   pend_hist[TAPS];
  bit   pend_v = 1'b0;
  int   pend_due = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // y = sum_k h_k * x_k with symmetric h, then round-half-up, shift and clip
  function automatic void ref_out(input int h[TAPS], input int sh, output longint d, output bit s);
    longint acc = 64'sd0;
    longint r;
    longint hi;
    longint lo;
    for (int k = 0; k < TAPS; k++)
      acc += longint'(h[k]) * longint'(active_m[(k < HALF) ? k : TAPS - 1 - k]);
    if (sh > 0) r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    else r = acc;
    hi = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    if (r > hi) begin d = hi; s = 1'b1; end
    else if (r < lo) begin d = lo; s = 1'b1; end
    else begin d = r; s = 1'b0; end
  endfunction

  // Model the effect of edge e; a sample's bank is whatever is active once the next edge's commit lands
  task automatic model_edge(input int e, input bit r, input bit v, input int d,
                            input bit we, input int a, input int cd, input bit cm);
    exp_t x;
    if (r) begin
      for (int i = 0; i < HALF; i++) begin shadow_m[i] = 0; active_m[i] = 0; end
      for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
      pend_v = 1'b0;
      while (sb_q.size() > 0 && sb_q[$].due >= e) void'(sb_q.pop_back());
      reset_due = e;
      if (mon_start > e) mon_start = e;
    end else begin
      if (cm) active_m = shadow_m;
      if (we && a < HALF) shadow_m[a] = cd;
      if (pend_v) begin
        x.due = pend_due;
        ref_out(pend_hist, SH0, x.d0, x.s0);
        ref_out(pend_hist, SH1, x.d1, x.s1);
        sb_q.push_back(x);
        pend_v = 1'b0;
      end
      if (v) begin
        for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = d;
        pend_hist = hist_m;
        pend_v = 1'b1;
        pend_due = e + 4;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int d, input bit we,
                      input int a, input int cd, input bit cm);
    @(posedge clk);
    #2;
    rst = r;
    bus0.din_valid = v;  bus1.din_valid = v;
    bus0.din = DATA_W'(d); bus1.din = DATA_W'(d);
    bus0.coef_we = we;   bus1.coef_we = we;
    bus0.coef_addr = ADDR_W'(a); bus1.coef_addr = ADDR_W'(a);
    bus0.coef_data = COEF_W'(cd); bus1.coef_data = COEF_W'(cd);
    bus0.coef_commit = cm; bus1.coef_commit = cm;
    model_edge(cyc + 1, r, v, d, we, a, cd, cm);
  endtask

  task automatic feed(input bit v, input int d);
    step(1'b0, v, d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic load_all(input int c0, input int c1, input int c2, input int c3,
                          input int c4, input int c5, input int c6, input int c7);
    int c[HALF];
    c = '{c0, c1, c2, c3, c4, c5, c6, c7};
    for (int i = 0; i < HALF; i++) step(1'b0, 1'b0, 0, 1'b1, i, c[i], 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
  endtask

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Monitor: outputs seen at the negedge after edge cyc
  longint last0 = 0, last1 = 0;
  bit     lsat0 = 1'b0, lsat1 = 1'b0;
  bit     mon_due;
  exp_t   mon_e;
  always @(negedge clk) begin
    if (cyc >= mon_start) begin
      if (cyc == reset_due) begin
        chk("rst_valid0", longint'(bus0.dout_valid), 0);
        chk("rst_dout0",  longint'(bus0.dout), 0);
        chk("rst_sat0",   longint'(bus0.dout_sat), 0);
        chk("rst_valid1", longint'(bus1.dout_valid), 0);
        chk("rst_dout1",  longint'(bus1.dout), 0);
        chk("rst_sat1",   longint'(bus1.dout_sat), 0);
        last0 = 0; last1 = 0; lsat0 = 1'b0; lsat1 = 1'b0;
      end else begin
        while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
          chk("missed_output_due", longint'(cyc), longint'(sb_q[0].due));
          void'(sb_q.pop_front());
        end
        mon_due = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        if (bus0.dout_valid || bus1.dout_valid || mon_due) begin
          chk("valid0", longint'(bus0.dout_valid), longint'(mon_due));
          chk("valid1", longint'(bus1.dout_valid), longint'(mon_due));
          if (mon_due) begin
            mon_e = sb_q.pop_front();
            chk("dout0", longint'(bus0.dout), mon_e.d0);
            chk("sat0",  longint'(bus0.dout_sat), longint'(mon_e.s0));
            chk("dout1", longint'(bus1.dout), mon_e.d1);
            chk("sat1",  longint'(bus1.dout_sat), longint'(mon_e.s1));
            last0 = mon_e.d0; lsat0 = mon_e.s0;
            last1 = mon_e.d1; lsat1 = mon_e.s1;
          end
        end else begin
          chk("hold_dout0", longint'(bus0.dout), last0);
          chk("hold_sat0",  longint'(bus0.dout_sat), longint'(lsat0));
          chk("hold_dout1", longint'(bus1.dout), last1);
          chk("hold_sat1",  longint'(bus1.dout_sat), longint'(lsat1));
        end
      end
    end
  end

  initial begin
    bus0.din_valid = 1'b0; bus1.din_valid = 1'b0;
    bus0.din = '0; bus1.din = '0;
    bus0.coef_we = 1'b0; bus1.coef_we = 1'b0;
    bus0.coef_addr = '0; bus1.coef_addr = '0;
    bus0.coef_data = '0; bus1.coef_data = '0;
    bus0.coef_commit = 1'b0; bus1.coef_commit = 1'b0;
    for (int i = 0; i < HALF; i++) begin shadow_m[i] = 0; active_m[i] = 0; end
    for (int k = 0; k < TAPS; k++) begin hist_m[k] = 0; pend_hist[k] = 0; end
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);

    // Impulse through coefficients 1..8
    load_all(1, 2, 3, 4, 5, 6, 7, 8);
    feed(1'b1, 1);
    for (int i = 0; i < 15; i++) feed(1'b1, 0);
    for (int i = 0; i < 6; i++) feed(1'b0, 0);

    // Same impulse with gaps; din wiggles while invalid
    for (int i = 0; i < 16; i++) begin
      feed(1'b1, (i == 0) ? 1 : 0);
      feed(1'b0, 55);
      feed(1'b0, -7);
    end
    for (int i = 0; i < 6; i++) feed(1'b0, 0);

    // Rounding on the centre pair
    load_all(0, 0, 0, 0, 0, 0, 0, 1);
    feed(1'b1, 3);
    for (int i = 0; i < 17; i++) feed(1'b1, 0);
    feed(1'b1, -3);
    for (int i = 0; i < 17; i++) feed(1'b1, 0);

    // Saturation both ways
    load_all(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
    for (int i = 0; i < 20; i++) feed(1'b1, 2047);
    for (int i = 0; i < 20; i++) feed(1'b1, -2048);

    // Commit timing with a live stream
    load_all(1, 1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 20; i++) feed(1'b1, 1);
    for (int i = 0; i < HALF; i++) step(1'b0, 1'b1, 1, 1'b1, i, 2, 1'b0);
    for (int i = 0; i < 10; i++) feed(1'b1, 1);
    step(1'b0, 1'b1, 1, 1'b1, 0, 5, 1'b1);
    for (int i = 0; i < 10; i++) feed(1'b1, 1);
    step(1'b0, 1'b1, 1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) feed(1'b1, 1);
    for (int i = 0; i < 6; i++) feed(1'b0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0, rnd12(), $urandom_range(0, 5) == 0,
           int'($urandom_range(0, HALF - 1)), rnd12(), $urandom_range(0, 15) == 0);
    end

    // Reset mid-stream, then zero output until reload
    load_all(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
    for (int i = 0; i < 10; i++) feed(1'b1, 2047);
    step(1'b1, 1'b1, 2047, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) feed(1'b1, rnd12());
    load_all(rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12());
    for (int i = 0; i < 50; i++) feed($urandom_range(0, 1) == 1, rnd12());
    for (int i = 0; i < 8; i++) feed(1'b0, 0);

    @(negedge clk);
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
